// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner encoding and default widths.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// master = arbiter view, slave = requesters/memory view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_wr;
  logic          mem_enable;
  logic [DW-1:0] mem_data_out;
  logic          mem_ready;

  logic          busy;
  logic          err;

  modport master (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out, mem_ready,
    output if_done, if_rdata, d_done, d_rdata, mem_addr, mem_data_in, mem_wr,
           mem_enable, busy, err
  );

  modport slave (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out, mem_ready,
    input  if_done, if_rdata, d_done, d_rdata, mem_addr, mem_data_in, mem_wr,
           mem_enable, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter_arb_starve_ctr.sv
// Priority decision between fetch and data, with a streak counter that
// forces a fetch grant after STARVE_LIMIT consecutive data grants.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   idle,
  input  logic   grant,
  input  logic   if_req,
  input  logic   d_req,
  output owner_e winner
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] streak_r;
  logic          at_limit_s;

  assign at_limit_s = (streak_r == SW'(STARVE_LIMIT));

  // Data wins unless fetch has waited through a full streak.
  always_comb begin
    winner = OWN_IF;
    if (d_req && !(if_req && at_limit_s)) begin
      winner = OWN_D;
    end else begin
      winner = OWN_IF;
    end
  end

  // Streak of data grants taken while fetch was waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_r <= {SW{1'b0}};
    end else if (idle && !if_req) begin
      streak_r <= {SW{1'b0}};
    end else if (grant) begin
      if (winner == OWN_IF) begin
        streak_r <= {SW{1'b0}};
      end else if (!at_limit_s) begin
        streak_r <= streak_r + SW'(1'b1);
      end else begin
        streak_r <= streak_r;
      end
    end else begin
      streak_r <= streak_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// Optional MEM_TIMEOUT_EN adds an ISSUE watchdog that sets a sticky err flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);
  state_e        state_r;
  state_e        state_nxt_s;
  owner_e        owner_r;
  owner_e        winner_s;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_data_in_r;
  logic          wr_r;
  logic          mem_enable_r;
  logic          mem_wr_r;
  logic          if_done_r;
  logic          d_done_r;
  logic          busy_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] d_rdata_r;
  logic          grant_s;
  logic          capture_s;
  logic          finish_s;
  logic          timeout_s;
  logic          err_s;
  logic          lat_wr_s;

  arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .idle   (state_r == IDLE),
    .grant  (grant_s),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .winner (winner_s)
  );

  assign lat_wr_s = (winner_s == OWN_D) && bus.d_wr;

  // Next-state logic; finish_s marks the ISSUE exit that produces a done pulse.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    capture_s   = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_nxt_s = ISSUE;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          state_nxt_s = RESP;
          capture_s   = 1'b1;
          finish_s    = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = RESP;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched request and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r       <= OWN_IF;
      mem_addr_r    <= {AW{1'b0}};
      mem_data_in_r <= {DW{1'b0}};
      wr_r          <= 1'b0;
      mem_enable_r  <= 1'b0;
      mem_wr_r      <= 1'b0;
      if_done_r     <= 1'b0;
      d_done_r      <= 1'b0;
      busy_r        <= 1'b0;
      if_rdata_r    <= {DW{1'b0}};
      d_rdata_r     <= {DW{1'b0}};
    end else begin
      if (grant_s) begin
        owner_r       <= winner_s;
        mem_addr_r    <= (winner_s == OWN_D) ? bus.d_addr : bus.if_addr;
        mem_data_in_r <= (winner_s == OWN_D) ? bus.d_wdata : {DW{1'b0}};
        wr_r          <= lat_wr_s;
      end
      mem_enable_r <= (state_nxt_s == ISSUE);
      mem_wr_r     <= (state_nxt_s == ISSUE) && (grant_s ? lat_wr_s : wr_r);
      if_done_r    <= finish_s && (owner_r == OWN_IF);
      d_done_r     <= finish_s && (owner_r == OWN_D);
      busy_r       <= (state_nxt_s != IDLE);
      if (capture_s && !wr_r) begin
        if (owner_r == OWN_IF) begin
          if_rdata_r <= bus.mem_data_out;
        end else begin
          d_rdata_r  <= bus.mem_data_out;
        end
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_r;
  logic          err_r;

  // ISSUE watchdog; a finish without capture can only be a timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= {CW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (state_r == ISSUE) begin
        tmo_cnt_r <= tmo_cnt_r + CW'(1'b1);
      end else begin
        tmo_cnt_r <= {CW{1'b0}};
      end
      if (finish_s && !capture_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign timeout_s = (tmo_cnt_r == CW'(TIMEOUT - 1));
  assign err_s     = err_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
  assign timeout_s        = 1'b0;
  assign err_s            = 1'b0;
`endif

  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_data_in = mem_data_in_r;
  assign bus.mem_wr      = mem_wr_r;
  assign bus.mem_enable  = mem_enable_r;
  assign bus.if_done     = if_done_r;
  assign bus.d_done      = d_done_r;
  assign bus.if_rdata    = if_rdata_r;
  assign bus.d_rdata     = d_rdata_r;
  assign bus.busy        = busy_r;
  assign bus.err         = err_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration and latency rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_streak = 0;
  logic [DW-1:0] exp_if_rdata = 32'h0;
  logic [DW-1:0] exp_d_rdata  = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_data_out = 32'h0;
  endtask

  // Predicts the winner and advances the streak for a grant from IDLE.
  task automatic model_grant(input logic ir, input logic dr, output owner_e w);
    if (ir && dr) w = (m_streak == LIM) ? OWN_IF : OWN_D;
    else if (dr)  w = OWN_D;
    else          w = OWN_IF;
    if (!ir)              m_streak = 0;
    else if (w == OWN_IF) m_streak = 0;
    else if (m_streak < LIM) m_streak = m_streak + 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++;
    if ({bus.busy, bus.mem_enable, bus.mem_wr, bus.if_done, bus.d_done, bus.err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy/en/wr/ifd/dd/err=%b exp 000000",
               {bus.busy, bus.mem_enable, bus.mem_wr, bus.if_done, bus.d_done, bus.err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_data_in, bus.if_rdata, bus.d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h d_rdata=%h exp all 0",
               bus.mem_addr, bus.mem_data_in, bus.if_rdata, bus.d_rdata);
    end
    rst = 1'b1;
    tick();
    m_streak = 0; exp_if_rdata = 32'h0; exp_d_rdata = 32'h0;
  endtask

  task automatic test_fetch_single();
    int en_cnt = 0, ifd_cnt = 0, dd_cnt = 0;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.mem_enable) begin
        en_cnt++;
        checks++;
        if (bus.mem_addr !== 32'h100 || bus.mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL fetch_addr: got addr=%h wr=%b exp 00000100 0", bus.mem_addr, bus.mem_wr);
        end
      end
      if (bus.if_done) ifd_cnt++;
      if (bus.d_done)  dd_cnt++;
      bus.mem_ready = (c == 3);
      bus.mem_data_out = (c == 3) ? 32'hDEADBEEF : 32'h0BADF00D;
      if (c >= 4) bus.if_req = 1'b0;
    end
    m_streak = 0; exp_if_rdata = 32'hDEADBEEF;
    checks++;
    if (en_cnt != 3) begin errors++; $display("FAIL fetch_enable_cycles: got %0d exp 3", en_cnt); end
    checks++;
    if (ifd_cnt != 1 || dd_cnt != 0) begin
      errors++; $display("FAIL fetch_done: got if_done=%0d d_done=%0d exp 1 0", ifd_cnt, dd_cnt);
    end
    checks++;
    if (bus.if_rdata !== exp_if_rdata) begin
      errors++; $display("FAIL fetch_rdata: got %h exp %h", bus.if_rdata, exp_if_rdata);
    end
  endtask

  task automatic test_data_write();
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h12345678;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({bus.mem_enable, bus.mem_wr} !== 2'b11 || bus.mem_addr !== 32'h2000 ||
          bus.mem_data_in !== 32'h12345678 || bus.d_done !== 1'b0) begin
        errors++;
        $display("FAIL write_issue: got en=%b wr=%b addr=%h data=%h dd=%b exp 1 1 00002000 12345678 0",
                 bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.d_done);
      end
      bus.mem_ready = (c == 2); bus.mem_data_out = 32'hCAFEF00D;
    end
    tick();
    bus.mem_ready = 1'b0; bus.d_req = 1'b0;
    checks++;
    if ({bus.d_done, bus.if_done, bus.mem_enable, bus.mem_wr} !== 4'b1000) begin
      errors++;
      $display("FAIL write_resp: got dd/ifd/en/wr=%b exp 1000",
               {bus.d_done, bus.if_done, bus.mem_enable, bus.mem_wr});
    end
    checks++;
    if (bus.d_rdata !== exp_d_rdata) begin
      errors++; $display("FAIL write_rdata_held: got %h exp %h", bus.d_rdata, exp_d_rdata);
    end
    tick();
    bus.d_wr = 1'b0;
    m_streak = 0;
  endtask

  task automatic test_starvation();
    owner_e w;
    logic [DW-1:0] word;
    bus.if_addr = 32'h4000; bus.d_addr = 32'h8000; bus.d_wr = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    for (int t = 0; t < 10; t++) begin
      model_grant(1'b1, 1'b1, w);
      word = $urandom();
      tick();
      checks++;
      if (bus.mem_enable !== 1'b1 || bus.mem_addr !== ((w == OWN_IF) ? 32'h4000 : 32'h8000)) begin
        errors++;
        $display("FAIL starve_grant%0d: got en=%b addr=%h exp 1 %h", t, bus.mem_enable,
                 bus.mem_addr, (w == OWN_IF) ? 32'h4000 : 32'h8000);
      end
      bus.mem_ready = 1'b1; bus.mem_data_out = word;
      tick();
      bus.mem_ready = 1'b0;
      if (w == OWN_IF) exp_if_rdata = word; else exp_d_rdata = word;
      checks++;
      if ({bus.if_done, bus.d_done} !== ((w == OWN_IF) ? 2'b10 : 2'b01) ||
          bus.if_rdata !== exp_if_rdata || bus.d_rdata !== exp_d_rdata) begin
        errors++;
        $display("FAIL starve_done%0d: got ifd/dd=%b rd=%h/%h exp owner=%0d rd=%h/%h", t,
                 {bus.if_done, bus.d_done}, bus.if_rdata, bus.d_rdata, w, exp_if_rdata, exp_d_rdata);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL starve_bubble%0d: got busy=%b exp 0", t, bus.busy); end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
    m_streak = 0;
  endtask

  task automatic test_random();
    logic if_p = 1'b0, d_p = 1'b0, dwr = 1'b0, exp_wr;
    logic [AW-1:0] ia = 32'h0, da = 32'h0, exp_addr;
    logic [DW-1:0] dwd = 32'h0, word;
    owner_e w;
    int k;
    for (int n = 0; n < 60; n++) begin
      if (!if_p && $urandom_range(0, 2) != 0) begin if_p = 1'b1; ia = $urandom(); end
      if (!d_p && $urandom_range(0, 2) != 0) begin
        d_p = 1'b1; da = $urandom(); dwr = 1'($urandom_range(0, 1)); dwd = $urandom();
      end
      bus.if_req = if_p; bus.if_addr = ia;
      bus.d_req = d_p; bus.d_addr = da; bus.d_wr = dwr; bus.d_wdata = dwd;
      if (!if_p && !d_p) begin
        m_streak = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        tick();
        bus.mem_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rand_idle%0d: got busy=%b exp 0", n, bus.busy); end
        continue;
      end
      model_grant(if_p, d_p, w);
      exp_addr = (w == OWN_IF) ? ia : da;
      exp_wr = (w == OWN_D) && dwr;
      k = $urandom_range(0, 3);
      word = $urandom();
      for (int c = 0; c <= k; c++) begin
        tick();
        checks++;
        if ({bus.busy, bus.mem_enable, bus.mem_wr, bus.if_done, bus.d_done} !== {2'b11, exp_wr, 2'b00} ||
            bus.mem_addr !== exp_addr || (exp_wr && bus.mem_data_in !== dwd)) begin
          errors++;
          $display("FAIL rand_issue%0d: got busy/en/wr/ifd/dd=%b addr=%h data=%h exp %b addr=%h data=%h",
                   n, {bus.busy, bus.mem_enable, bus.mem_wr, bus.if_done, bus.d_done}, bus.mem_addr,
                   bus.mem_data_in, {2'b11, exp_wr, 2'b00}, exp_addr, dwd);
        end
        bus.mem_ready = (c == k);
        bus.mem_data_out = (c == k) ? word : $urandom();
      end
      tick();
      if (!exp_wr) begin
        if (w == OWN_IF) exp_if_rdata = word; else exp_d_rdata = word;
      end
      checks++;
      if ({bus.if_done, bus.d_done, bus.mem_enable, bus.mem_wr, bus.err} !==
          {(w == OWN_IF), (w == OWN_D), 3'b000} ||
          bus.if_rdata !== exp_if_rdata || bus.d_rdata !== exp_d_rdata) begin
        errors++;
        $display("FAIL rand_resp%0d: got ifd/dd/en/wr/err=%b rd=%h/%h exp owner=%0d rd=%h/%h", n,
                 {bus.if_done, bus.d_done, bus.mem_enable, bus.mem_wr, bus.err},
                 bus.if_rdata, bus.d_rdata, w, exp_if_rdata, exp_d_rdata);
      end
      if (w == OWN_IF) begin if_p = 1'b0; bus.if_req = 1'b0; end
      else begin d_p = 1'b0; bus.d_req = 1'b0; end
      bus.mem_ready = 1'($urandom_range(0, 1));
      tick();
      bus.mem_ready = 1'b0;
      checks++;
      if ({bus.busy, bus.if_done, bus.d_done} !== 3'b000) begin
        errors++;
        $display("FAIL rand_bubble%0d: got busy/ifd/dd=%b exp 000", n, {bus.busy, bus.if_done, bus.d_done});
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
    m_streak = 0;
  endtask

  task automatic test_reset_mid();
    bus.if_addr = 32'h300; bus.if_req = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.mem_enable} !== 2'b11) begin
      errors++; $display("FAIL midrst_pre: got busy/en=%b exp 11", {bus.busy, bus.mem_enable});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.mem_enable, bus.if_done, bus.d_done, bus.if_rdata != 32'h0} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_async: got busy/en/ifd/dd=%b rdata=%h exp 0000 0",
               {bus.busy, bus.mem_enable, bus.if_done, bus.d_done}, bus.if_rdata);
    end
    tick();
    bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_data_out = 32'h55AA55AA;
    rst = 1'b1;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; m_streak = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({bus.busy, bus.mem_enable, bus.if_done, bus.d_done} !== 4'b0 || bus.if_rdata !== 32'h0) begin
        errors++;
        $display("FAIL midrst_after%0d: got busy/en/ifd/dd=%b rdata=%h exp 0000 0", c,
                 {bus.busy, bus.mem_enable, bus.if_done, bus.d_done}, bus.if_rdata);
      end
      bus.mem_ready = ~bus.mem_ready;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_ready_idle();
    for (int c = 0; c < 6; c++) begin
      bus.mem_ready = c[0];
      tick();
      checks++;
      if ({bus.busy, bus.mem_enable, bus.if_done, bus.d_done} !== 4'b0) begin
        errors++;
        $display("FAIL ready_idle%0d: got busy/en/ifd/dd=%b exp 0000", c,
                 {bus.busy, bus.mem_enable, bus.if_done, bus.d_done});
      end
    end
    bus.mem_ready = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int en_cnt = 0;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 32'h700; bus.mem_ready = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      tick();
      if (bus.mem_enable) en_cnt++;
    end
    checks++;
    if (en_cnt != TMO || bus.err !== 1'b0 || bus.d_done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_wait: got en_cycles=%0d err=%b dd=%b exp %0d 0 0", en_cnt, bus.err, bus.d_done, TMO);
    end
    tick();
    bus.d_req = 1'b0;
    checks++;
    if ({bus.d_done, bus.if_done, bus.err} !== 3'b101 || bus.d_rdata !== exp_d_rdata) begin
      errors++;
      $display("FAIL tmo_resp: got dd/ifd/err=%b rdata=%h exp 101 %h",
               {bus.d_done, bus.if_done, bus.err}, bus.d_rdata, exp_d_rdata);
    end
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h900;
    tick();
    bus.mem_ready = 1'b1; bus.mem_data_out = 32'h0F0F1234;
    tick();
    bus.mem_ready = 1'b0; bus.if_req = 1'b0;
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h0F0F1234 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_next: got ifd=%b rdata=%h err=%b exp 1 0f0f1234 1", bus.if_done, bus.if_rdata, bus.err);
    end
    tick();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_single();
    test_data_write();
    test_starvation();
    test_random();
    test_ready_idle();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
